// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception detection, priority encoding and the
// IDLE -> FLUSH -> RECOVER pipeline flush sequence.
// Optional macro EXC_INT_SYNC_EN: route int_async_i through a 2-flop synchronizer.
module except_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_excepttype_i,
  input  logic [31:0] mem_current_inst_addr_i,
  input  logic        mem_is_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  input  logic [5:0]  int_async_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [5:0]  int_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] status_eff, cause_eff, epc_eff;
  logic [31:0] exc_code;
  logic        int_pending, detect;
  logic [31:0] type_nxt, pc_nxt, addr_nxt;
  logic        flush_nxt, ds_nxt;
  logic        unused_bits;

  // Effective CP0 values: forward a pending WB write of the same register
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        5'd12: status_eff = wb_cp0_wdata_i;
        5'd13: begin
          // only the software-writable cause fields are forwarded
          cause_eff[9:8]   = wb_cp0_wdata_i[9:8];
          cause_eff[23:22] = wb_cp0_wdata_i[23:22];
        end
        5'd14: epc_eff = wb_cp0_wdata_i;
        default: ;
      endcase
    end
  end

  assign int_pending = ((cause_eff[15:8] & status_eff[15:8]) != 8'h00) &&
                       !status_eff[1] && status_eff[0];

  // Priority encode the exception type, interrupt highest
  always_comb begin
    exc_code = '0;
    if (int_pending)              exc_code = 32'h0000_0001;
    else if (mem_excepttype_i[8])  exc_code = 32'h0000_0008;
    else if (mem_excepttype_i[9])  exc_code = 32'h0000_000a;
    else if (mem_excepttype_i[10]) exc_code = 32'h0000_000d;
    else if (mem_excepttype_i[11]) exc_code = 32'h0000_000c;
    else if (mem_excepttype_i[12]) exc_code = 32'h0000_000e;
  end

  assign detect = (state == IDLE) && (mem_current_inst_addr_i != '0) && (exc_code != '0);

  // Next-state and next-output logic; outputs are nonzero only for the FLUSH cycle
  always_comb begin
    state_nxt = state;
    type_nxt  = '0;
    pc_nxt    = '0;
    flush_nxt = 1'b0;
    addr_nxt  = current_inst_addr_o;
    ds_nxt    = is_in_delayslot_o;
    case (state)
      IDLE: begin
        if (detect) begin
          state_nxt = FLUSH;
          type_nxt  = exc_code;
          flush_nxt = 1'b1;
          pc_nxt    = (exc_code == 32'h0000_000e) ? epc_eff : 32'h0000_0020;
          addr_nxt  = mem_current_inst_addr_i;
          ds_nxt    = mem_is_in_delayslot_i;
        end
      end
      FLUSH:   state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      is_in_delayslot_o   <= 1'b0;
      flush_o             <= 1'b0;
      new_pc_o            <= '0;
    end else begin
      state               <= state_nxt;
      excepttype_o        <= type_nxt;
      current_inst_addr_o <= addr_nxt;
      is_in_delayslot_o   <= ds_nxt;
      flush_o             <= flush_nxt;
      new_pc_o            <= pc_nxt;
    end
  end

`ifdef EXC_INT_SYNC_EN
  logic [5:0] int_meta, int_sync;

  // Two-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_meta <= '0;
      int_sync <= '0;
    end else begin
      int_meta <= int_async_i;
      int_sync <= int_meta;
    end
  end

  assign int_o = int_sync;
`else
  assign int_o = int_async_i;
`endif

  assign unused_bits = ^{mem_excepttype_i[31:13], mem_excepttype_i[7:0],
                         status_eff[31:16], status_eff[7:2],
                         cause_eff[31:16], cause_eff[7:0]};

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 clk  in  1  sole clock, rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 mem_excepttype_i  in  32  raw MEM-stage flags: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret.
REQ-004 mem_current_inst_addr_i  in  32  PC of MEM-stage instruction; 0 = bubble.
REQ-005 mem_is_in_delayslot_i  in  1  MEM-stage instruction is in a delay slot.
REQ-006 cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values.
REQ-007 wb_cp0_we_i  in  1; wb_cp0_waddr_i  in  5; wb_cp0_wdata_i  in  32  pending CP0 write in WB, used for bypass.
REQ-008 int_async_i  in  6  raw external interrupt lines.
REQ-009 excepttype_o  out  32  encoded exception type to CP0: 0x1 int, 0x8 syscall, 0xa invalid inst, 0xd trap, 0xc overflow, 0xe eret, 0 none.
REQ-010 current_inst_addr_o  out  32; is_in_delayslot_o  out  1  faulting PC and delay-slot flag, aligned with excepttype_o.
REQ-011 int_o  out  6  interrupt lines presented to CP0 cause[15:10].
REQ-012 flush_o  out  1  pipeline flush pulse; new_pc_o  out  32  redirect target.

Function
REQ-013 Effective status = cp0_status_i unless wb_cp0_we_i and waddr = 12, then wb_cp0_wdata_i.
REQ-014 Effective epc = cp0_epc_i unless wb_cp0_we_i and waddr = 14, then wb_cp0_wdata_i.
REQ-015 Effective cause = cp0_cause_i, except bits 9:8, 22, 23 are taken from wb_cp0_wdata_i when wb_cp0_we_i and waddr = 13.
REQ-016 Interrupt pending = (cause[15:8] & status[15:8]) != 0 and status[1] (EXL) = 0 and status[0] (IE) = 1, all effective values.
REQ-017 Detection is enabled only in state IDLE and only when mem_current_inst_addr_i != 0.
REQ-018 Priority, highest first: interrupt, syscall, invalid inst, trap, overflow, eret; exactly one type is encoded.
REQ-019 FSM states: IDLE, FLUSH, RECOVER. IDLE->FLUSH on detection; FLUSH->RECOVER unconditionally; RECOVER->IDLE unconditionally.
REQ-020 Latency: detection at edge N; at edge N+1 excepttype_o, current_inst_addr_o, is_in_delayslot_o, flush_o=1 and new_pc_o are registered and hold for exactly one cycle (state FLUSH).
REQ-021 new_pc_o = 0x00000020 for all types except eret, for which new_pc_o = effective epc sampled at detection.
REQ-022 Outside FLUSH: excepttype_o = 0, flush_o = 0, new_pc_o = 0; current_inst_addr_o and is_in_delayslot_o hold last value.
REQ-023 In RECOVER, flags on inputs are ignored (no second exception from the flushed slot).
REQ-024 Simultaneous WB CP0 write and detection: the bypassed value is used (REQ-013..015).

Reset
REQ-025 While rst = 0: state = IDLE; all outputs 0; synchronizer flops 0; takes effect without a clock edge.
REQ-026 Reset asserted in FLUSH or RECOVER aborts the sequence; first post-reset cycle is IDLE with flush_o = 0.

Configuration
REQ-027 Macro EXC_INT_SYNC_EN defined: int_o = int_async_i through a 2-flop synchronizer (2-cycle latency, reset to 0).
REQ-028 EXC_INT_SYNC_EN undefined: int_o = int_async_i combinationally; no synchronizer flops exist.

Verification
REQ-029 mem_excepttype_i bit8=1, addr 0x100, status 0x10000001 -> next cycle excepttype_o=0x8, flush_o=1, new_pc_o=0x20, current_inst_addr_o=0x100, then flush_o=0 for the next 2 cycles.
REQ-030 bit12=1, cp0_epc_i=0x200, WB writes EPC=0x300 in the same cycle -> excepttype_o=0xe, new_pc_o=0x300.
REQ-031 cause[10]=1, status=0x10000401, bit11=1, addr 0x80 -> excepttype_o=0x1 (interrupt beats overflow); with status[1]=1 -> excepttype_o=0xc.
REQ-032 bit9=1 held for 4 cycles -> exactly one flush pulse per 3-cycle sequence (FLUSH at edge N+1, next detection at edge N+3).
REQ-033 Exception with mem_current_inst_addr_i=0 -> no flush; rst driven low mid-FLUSH -> flush_o=0 immediately, IDLE after release.
REQ-034 With EXC_INT_SYNC_EN, int_async_i 0->0x01 -> int_o=0x01 after 2 edges; without it, same cycle.
